// File: rtl/hash_dispatch.sv
// hash_dispatch: sweeps the nonce field of a decoded block through one SHA-256
// core and reports the first nonce whose digest is below the target, or that
// the nonce space was exhausted.
// Optional build macro HASH_DISPATCH_STATS_EN adds a saturating hash_count port.
//
// Handshake: result_valid rises with result_found/result_nonce and holds them
// until result_ready is sampled high; the transfer completes on that edge and
// result_valid falls the next cycle. result_ready while result_valid is low
// has no effect.
module hash_dispatch #(
    parameter int MSG_W     = 512,
    parameter int HASH_W    = 256,
    parameter int NONCE_W   = 32,
    parameter int NONCE_LSB = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_block,
    input  logic [MSG_W-1:0]   data_to_hash,
    input  logic [HASH_W-1:0]  difficulty,
    output logic               hash_start,
    output logic [MSG_W-1:0]   hash_msg,
    input  logic               hash_done,
    input  logic [HASH_W-1:0]  hash_out,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               result_found,
    output logic [NONCE_W-1:0] result_nonce,
`ifdef HASH_DISPATCH_STATS_EN
    output logic [31:0]        hash_count,
`endif
    output logic               busy,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        CHECK  = 3'd3,
        REPORT = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [MSG_W-1:0]     msg_q, msg_d;
    logic [HASH_W-1:0]    target_q, target_d;
    logic [NONCE_W-1:0]   nonce_q, nonce_d;
    logic [HASH_W-1:0]    digest_q, digest_d;
    logic                 stale_q, stale_d;
    logic                 hash_start_q, hash_start_d;
    logic [MSG_W-1:0]     hash_msg_q, hash_msg_d;
    logic                 result_valid_q, result_valid_d;
    logic                 result_found_q, result_found_d;
    logic [NONCE_W-1:0]   result_nonce_q, result_nonce_d;
    logic                 busy_q, busy_d;
    logic [MSG_W-1:0]     msg_with_nonce;

    // State register and registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            msg_q          <= '0;
            target_q       <= '0;
            nonce_q        <= '0;
            digest_q       <= '0;
            stale_q        <= 1'b0;
            hash_start_q   <= 1'b0;
            hash_msg_q     <= '0;
            result_valid_q <= 1'b0;
            result_found_q <= 1'b0;
            result_nonce_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            msg_q          <= msg_d;
            target_q       <= target_d;
            nonce_q        <= nonce_d;
            digest_q       <= digest_d;
            stale_q        <= stale_d;
            hash_start_q   <= hash_start_d;
            hash_msg_q     <= hash_msg_d;
            result_valid_q <= result_valid_d;
            result_found_q <= result_found_d;
            result_nonce_q <= result_nonce_d;
            busy_q         <= busy_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they are
    // registered yet line up with the state they belong to.
    always_comb begin
        state_d        = state_q;
        msg_d          = msg_q;
        target_d       = target_q;
        nonce_d        = nonce_q;
        digest_d       = digest_q;
        stale_d        = stale_q;
        result_found_d = result_found_q;
        result_nonce_d = result_nonce_q;

        case (state_q)
            IDLE: begin
                if (new_block) begin
                    msg_d    = data_to_hash;
                    target_d = difficulty;
                    nonce_d  = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (new_block) begin
                    msg_d    = data_to_hash;
                    target_d = difficulty;
                    nonce_d  = '0;
                    state_d  = ISSUE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (new_block) begin
                    // The in-flight hash belongs to the old block; keep waiting
                    // for it unless it completes right now, then reissue.
                    msg_d    = data_to_hash;
                    target_d = difficulty;
                    nonce_d  = '0;
                    if (hash_done) begin
                        stale_d = 1'b0;
                        state_d = ISSUE;
                    end else begin
                        stale_d = 1'b1;
                    end
                end else if (hash_done) begin
                    if (stale_q) begin
                        stale_d = 1'b0;
                        state_d = ISSUE;
                    end else begin
                        digest_d = hash_out;
                        state_d  = CHECK;
                    end
                end
            end
            CHECK: begin
                if (new_block) begin
                    msg_d    = data_to_hash;
                    target_d = difficulty;
                    nonce_d  = '0;
                    state_d  = ISSUE;
                end else if (digest_q < target_q) begin
                    result_found_d = 1'b1;
                    result_nonce_d = nonce_q;
                    state_d        = REPORT;
                end else if (&nonce_q) begin
                    result_found_d = 1'b0;
                    result_nonce_d = nonce_q;
                    state_d        = REPORT;
                end else begin
                    nonce_d = nonce_q + {{(NONCE_W-1){1'b0}}, 1'b1};
                    state_d = ISSUE;
                end
            end
            REPORT: begin
                if (new_block) begin
                    msg_d    = data_to_hash;
                    target_d = difficulty;
                    nonce_d  = '0;
                    state_d  = ISSUE;
                end else if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        msg_with_nonce = msg_d;
        msg_with_nonce[NONCE_LSB +: NONCE_W] = nonce_d;

        hash_start_d   = (state_d == ISSUE);
        hash_msg_d     = (state_d == ISSUE) ? msg_with_nonce : hash_msg_q;
        result_valid_d = (state_d == REPORT);
        busy_d         = (state_d != IDLE);
    end

`ifdef HASH_DISPATCH_STATS_EN
    logic [31:0] hash_count_q, hash_count_d;

    // Saturating count of hash_start pulses, including discarded attempts.
    always_comb begin
        hash_count_d = hash_count_q;
        if (hash_start_d && (hash_count_q != 32'hFFFF_FFFF)) begin
            hash_count_d = hash_count_q + 32'd1;
        end
    end

    // Counter register; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hash_count_q <= '0;
        end else begin
            hash_count_q <= hash_count_d;
        end
    end

    assign hash_count = hash_count_q;
`endif

    assign hash_start   = hash_start_q;
    assign hash_msg     = hash_msg_q;
    assign result_valid = result_valid_q;
    assign result_found = result_found_q;
    assign result_nonce = result_nonce_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/hash_dispatch.md
Name: hash_dispatch

Overview:
- Sits directly downstream of the packet decoder in the USB miner datapath.
- Consumes each decoded block (512-bit message plus 256-bit difficulty target) when the decoder pulses new_block.
- Sweeps the nonce field through a single SHA-256 core, one hash per attempt, comparing each digest against the target.
- Reports a winning nonce, or exhaustion of the nonce space, to the host-side result logic through a valid/ready handshake.

Parameters:
- MSG_W, 512, width of message block handed to hash core
- HASH_W, 256, width of digest and difficulty target
- NONCE_W, 32, width of nonce counter
- NONCE_LSB, 0, bit position in message where nonce field starts (field = [NONCE_LSB +: NONCE_W])

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- new_block  in  1  one-cycle pulse from packet decoder: data_to_hash/difficulty valid
- data_to_hash  in  MSG_W  decoded message block
- difficulty  in  HASH_W  target; a hit requires digest < difficulty
- hash_start  out  1  one-cycle pulse launching hash core
- hash_msg  out  MSG_W  message with nonce inserted; stable from hash_start until hash_done
- hash_done  in  1  one-cycle pulse from hash core: hash_out valid
- hash_out  in  HASH_W  digest
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- result_found  out  1  1 = hit, 0 = nonce space exhausted
- result_nonce  out  NONCE_W  nonce of hit, or final nonce tried
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: synchronous, active-high, takes effect at the next clk edge. All outputs 0; nonce 0; latched message and target 0; state IDLE. Reset overrides every other input, including mid-hash; a hash_done arriving after reset is ignored in IDLE.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, CHECK, REPORT.
- IDLE:
  - On new_block: latch data_to_hash and difficulty, set nonce = 0, go to ISSUE.
- ISSUE:
  - hash_start = 1 for exactly one cycle.
  - hash_msg = latched message with [NONCE_LSB +: NONCE_W] replaced by nonce.
  - Go to WAIT.
  - Latency: new_block sampled at edge k produces hash_start high in cycle k+1.
- WAIT:
  - On hash_done: register hash_out, go to CHECK.
  - hash_done in any other state is ignored.
- CHECK (one cycle):
  - Comparison is unsigned, full HASH_W width, strictly less-than.
  - If digest < target: go to REPORT with found = 1.
  - Else if nonce == all ones: go to REPORT with found = 0; no wrap to 0.
  - Else: nonce + 1, go to ISSUE.
  - Attempt period = 3 + (hash core latency − 1) cycles.
- REPORT:
  - result_valid = 1; result_found and result_nonce held stable until result_ready is sampled high.
  - On acceptance: result_valid drops the next cycle, go to IDLE.
  - result_ready while result_valid is low has no effect.
- new_block while busy (restart; newest block always wins):
  - In ISSUE, CHECK or REPORT: relatch message and target, nonce = 0, drop result_valid, go to ISSUE.
  - In WAIT: relatch immediately and set a stale flag; stay in WAIT. The next hash_done is discarded (no compare), the flag clears, and the block goes to ISSUE with nonce 0.
  - new_block coincident with hash_done in WAIT: treat as restart; discard that digest.
- hash_msg keeps its last value outside ISSUE/WAIT.

Optional Feature:
- Macro: HASH_DISPATCH_STATS_EN.
- Defined:
  - Adds output port hash_count [31:0]: total hash_start pulses since reset.
  - Saturates at 32'hFFFF_FFFF; not cleared by new_block; cleared only by rst.
  - Stale (discarded) hashes are counted.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: hold rst for 2 cycles mid-WAIT → all outputs 0, busy 0; a following hash_done produces no hash_start and no result_valid.
- First-try hit:
  - Stimulus: new_block with data = {16{32'hA5A5_A5A5}}, difficulty = 256'h0000_FFFF…FF; model returns hash_out = 256'h1 after 4 cycles.
  - Required: hash_start in cycle k+1; hash_msg[31:0] = 0.
  - Required: result_valid with found = 1, nonce = 0, held 5 cycles until result_ready; then busy = 0.
- Hit at nonce 3: model returns digest = difficulty + 1 for nonces 0–2 and 0 for nonce 3 → exactly 4 hash_start pulses with hash_msg[31:0] = 0,1,2,3; result_nonce = 3, found = 1.
- Equality boundary: digest == difficulty on nonce 0 → no hit; nonce 1 issued.
- Exhaustion (NONCE_W = 4): digest always all ones → 16 attempts; result_found = 0, result_nonce = 4'hF; no 17th hash_start.
- Restart in WAIT:
  - Stimulus: second new_block with data = all zeros during WAIT; hash_done then returns digest 0.
  - Required: that digest is discarded; next hash_start carries all-zero data with nonce 0; result_nonce reflects the new block only.
  - With HASH_DISPATCH_STATS_EN defined: hash_count includes the stale attempt.
